seq_detector: RTL and testbench
===============================

# seq_detector

Parametrised serial pattern detector, successor to the team's fixed two-bit Mealy detector. It compares a serial bit stream against a runtime-loadable pattern of PAT_W bits and supports both overlapping and non-overlapping detection. The match output is registered, and an optional saturating match counter is included. It sits directly on a serial input path and its outputs feed status or interrupt logic.

## Interface
- PAT_W, default 4: pattern length in bits; legal range 2..16.
- CNT_W, default 8: width of the match counter.
- clk, input, 1: clock; all logic is rising-edge.
- rst, input, 1: reset, asynchronous, active-high.
- in_valid, input, 1: in_bit is a valid sample this cycle.
- in_bit, input, 1: serial data bit.
- pat_load, input, 1: load pat_value as the new pattern.
- pat_value, input, PAT_W: pattern; bit PAT_W-1 is the first bit received.
- overlap, input, 1: 1 selects overlapping detection, 0 selects non-overlapping; sampled with each valid sample.
- cnt_clr, input, 1: synchronous clear of match_count.
- match, output, 1: registered one-cycle pulse per detected pattern.
- armed, output, 1: high when the history holds PAT_W valid bits (state ARMED).
- match_count, output, CNT_W: saturating number of matches.

## Operation
- **State machine states**
  - IDLE: no pattern loaded; samples are ignored.
  - FILL: fill counter is below PAT_W.
  - ARMED: fill equals PAT_W; every valid sample is compared.
- **Pattern load:** pat_load in any state captures pat_value, clears the history and fill, and enters FILL.
  - pat_load has priority over in_valid in the same cycle; that sample is discarded.
- **History update:** on in_valid in FILL or ARMED, the history register shifts left with in_bit entering at the LSB.
  - In FILL, fill increments; reaching PAT_W moves the state to ARMED.
- **Match condition:** the updated history (including the current bit) equals the pattern, and the state is ARMED, or the state is FILL with fill equal to PAT_W-1.
  - On a match, match is set for the next cycle.
- **After a match, overlap=1:** remain in ARMED; the history is kept.
- **After a match, overlap=0:** fill is cleared and the state returns to FILL. The next match needs PAT_W fresh bits.
- **No sample:** in_valid=0 holds the history, fill and state. match is 0 in the following cycle.
- **Counter:** match_count increments on each match and saturates at all-ones.
  - cnt_clr clears it.
  - cnt_clr and a match in the same cycle yield 1.
- **Reset values:** state IDLE, pattern 0, history 0, fill 0, match 0, armed 0, match_count 0.
- **Reset mid-stream:** rst discards any partial history. A pattern must be reloaded after reset.

## Timing
- Match latency is one cycle: the sample completing the pattern arrives at edge N, and match is high from edge N to edge N+1.
- Back-to-back matches in overlap mode give match high on consecutive cycles.
- armed is registered and goes high one cycle after the PAT_W-th valid bit following a load or a non-overlap match.
- The pattern and mode take effect from the cycle after the load.
- There is no combinational path from inputs to outputs.

## Configuration
- **SEQDET_COUNT_EN defined:** the counter and cnt_clr logic are built as described.
- **SEQDET_COUNT_EN undefined:**
  - match_count is tied to 0.
  - cnt_clr is ignored.
  - No counter flops are built.
  - match, armed and the state machine are unchanged.

## Structure
- Shared package seqdet_pkg holds:
  - the state enum IDLE/FILL/ARMED, 2 bits;
  - the PAT_W legal-range constants;
  - the fill width, defined as clog2(PAT_W+1).
- One sub-module, seqdet_sat_counter: a CNT_W saturating up-counter with synchronous clear. It is instantiated only under SEQDET_COUNT_EN.

## Test plan
- **Overlap, repeating pattern:** PAT_W=4, load 1011, overlap=1, valid stream 1,0,1,1,0,1,1 → match pulses after the 4th and 7th samples; match_count=2.
- **Non-overlap, repeating pattern:** same stream with overlap=0 → match only after the 4th sample; match_count=1; armed low after the match until 4 more bits have arrived.
- **All-ones pattern:** load 1111, six ones with overlap=1 → matches on samples 4, 5 and 6. With overlap=0 → match on sample 4 only.
- **Load collision and idle cycles:** pat_load in the same cycle as in_valid=1 → that sample is ignored and fill is 0. in_valid gaps inside the pattern → match still occurs, with no spurious pulse.
- **Saturation:** CNT_W=2, five matches → match_count=3. cnt_clr together with a match → 1.
- **Reset mid-stream:** rst after 3 of the 4 pattern bits → all outputs 0 and state IDLE. Samples give no match until a pattern is reloaded. Rerun the regression with SEQDET_COUNT_EN undefined → match_count stays 0 throughout.

Source files
------------

// File: rtl/seqdet_pkg.sv
// Shared types and constants for the serial pattern detector.
// Imported by the detector top and its interface users.
package seqdet_pkg;

    // Detector states: no pattern, collecting bits, comparing every bit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } seqdet_state_e;

    // Legal pattern lengths.
    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

    // Width of the fill counter, which must be able to hold PAT_W itself.
    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seqdet_if.sv
// Serial input, pattern control and status bundle of the detector.
// master drives samples and control; slave is the detector.
interface seqdet_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);

    logic             in_valid;
    logic             in_bit;
    logic             pat_load;
    logic [PAT_W-1:0] pat_value;
    logic             overlap;
    logic             cnt_clr;
    logic             match;
    logic             armed;
    logic [CNT_W-1:0] match_count;

    modport master (
        output in_valid,
        output in_bit,
        output pat_load,
        output pat_value,
        output overlap,
        output cnt_clr,
        input  match,
        input  armed,
        input  match_count
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  pat_load,
        input  pat_value,
        input  overlap,
        input  cnt_clr,
        output match,
        output armed,
        output match_count
    );

endinterface

// File: rtl/seqdet_sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear in the same cycle as an increment leaves the count at one.
module seqdet_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count events, sticking at all-ones; clear restarts from this cycle's event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= W'(inc);
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Runtime-loadable serial pattern detector, overlapping or not.
// Optional saturating match counter built when SEQDET_COUNT_EN is defined.
module seq_detector
    import seqdet_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic    clk,
    input  logic    rst,
    seqdet_if.slave bus
);

    localparam int FW = fill_w(PAT_W);
    localparam logic [FW-1:0] FILL_LAST = FW'(PAT_W - 1);

    if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
        $error("seq_detector: PAT_W out of range");
    end

    seqdet_state_e    state_q;
    seqdet_state_e    state_d;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] pat_d;
    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] hist_d;
    logic [PAT_W-1:0] hist_sh;
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_d;
    logic             match_q;
    logic             armed_q;
    logic             armed_d;
    logic             hit;

    // History as it would look with the current bit shifted in at the LSB.
    assign hist_sh = {hist_q[PAT_W-2:0], bus.in_bit};

    // State, pattern, history and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= hit;
            armed_q <= armed_d;
        end
    end

    // Next-state logic: a load wins over a sample in the same cycle.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        hit     = 1'b0;
        if (bus.pat_load) begin
            pat_d   = bus.pat_value;
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILL;
        end else if (bus.in_valid) begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                FILL: begin
                    hist_d = hist_sh;
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FILL_LAST) begin
                        hit     = (hist_sh == pat_q);
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    hist_d = hist_sh;
                    hit    = (hist_sh == pat_q);
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            // Non-overlapping mode demands a full set of fresh bits.
            if (hit && !bus.overlap) begin
                fill_d  = '0;
                state_d = FILL;
            end
        end
        armed_d = (state_d == ARMED);
    end

    assign bus.match = match_q;
    assign bus.armed = armed_q;

`ifdef SEQDET_COUNT_EN
    seqdet_sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.cnt_clr),
        .inc   (hit),
        .count (bus.match_count)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr  = bus.cnt_clr;
    assign bus.match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector with PAT_W=4, CNT_W=2.
// Count expectations follow whether SEQDET_COUNT_EN is defined.
module tb_seq_detector;
    import seqdet_pkg::*;

`ifdef SEQDET_COUNT_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    seqdet_if #(.PAT_W(4), .CNT_W(2)) bus ();

    seq_detector #(
        .PAT_W (4),
        .CNT_W (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ec(input int n);
        return CE ? n : 0;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic b, input logic clr, input logic em,
                          input string tag);
        @(negedge clk);
        bus.pat_load = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        bus.cnt_clr  = clr;
        @(posedge clk);
        #1;
        chk(tag, int'(bus.match), int'(em));
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        bus.pat_load = 1'b0;
        bus.in_valid = 1'b0;
        bus.cnt_clr  = 1'b0;
        @(posedge clk);
        #1;
        chk(tag, int'(bus.match), 0);
    endtask

    task automatic clr_cycle(input string tag);
        @(negedge clk);
        bus.pat_load = 1'b0;
        bus.in_valid = 1'b0;
        bus.cnt_clr  = 1'b1;
        @(posedge clk);
        #1;
        chk(tag, int'(bus.match_count), 0);
    endtask

    task automatic load(input logic [3:0] pat, input logic ov,
                        input logic v, input logic b);
        @(negedge clk);
        bus.pat_load  = 1'b1;
        bus.pat_value = pat;
        bus.overlap   = ov;
        bus.in_valid  = v;
        bus.in_bit    = b;
        bus.cnt_clr   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [15:0] bits, input logic [15:0] em,
                       input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            sample(bits[i], 1'b0, em[i], $sformatf("%s[%0d]", tag, n - i));
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.pat_load  = 1'b0;
        bus.pat_value = '0;
        bus.overlap   = 1'b0;
        bus.cnt_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_match", int'(bus.match), 0);
        chk("rst_armed", int'(bus.armed), 0);
        chk("rst_count", int'(bus.match_count), 0);
        chk("rst_state", int'(dut.state_q), int'(IDLE));
        @(negedge clk);
        rst = 1'b0;

        // No pattern loaded: zeros must not match the reset pattern.
        run(16'b0000, 16'b0000, 4, "idle_zero");
        chk("idle_armed", int'(bus.armed), 0);

        // Overlap, 1011 over 1011011.
        load(4'b1011, 1'b1, 1'b0, 1'b0);
        run(16'b101, 16'b000, 3, "ov_a");
        chk("ov_armed3", int'(bus.armed), 0);
        run(16'b1011, 16'b1001, 4, "ov_b");
        chk("ov_armed7", int'(bus.armed), 1);
        chk("ov_count", int'(bus.match_count), ec(2));
        idle("ov_gap");

        // Non-overlap, same stream plus one extra bit.
        clr_cycle("clr1");
        load(4'b1011, 1'b0, 1'b0, 1'b0);
        run(16'b1011, 16'b0001, 4, "nov_a");
        chk("nov_armed4", int'(bus.armed), 0);
        run(16'b011, 16'b000, 3, "nov_b");
        chk("nov_armed7", int'(bus.armed), 0);
        sample(1'b1, 1'b0, 1'b0, "nov_8");
        chk("nov_armed8", int'(bus.armed), 1);
        chk("nov_count", int'(bus.match_count), ec(1));

        // All-ones pattern.
        clr_cycle("clr2");
        load(4'b1111, 1'b1, 1'b0, 1'b0);
        run(16'b111111, 16'b000111, 6, "ones_ov");
        chk("ones_count", int'(bus.match_count), ec(3));
        load(4'b1111, 1'b0, 1'b0, 1'b0);
        run(16'b111111, 16'b000100, 6, "ones_nov");

        // Load collision: the concurrent sample is dropped.
        load(4'b1011, 1'b1, 1'b1, 1'b1);
        chk("col_armed0", int'(bus.armed), 0);
        run(16'b011, 16'b000, 3, "col");
        chk("col_armed3", int'(bus.armed), 0);

        // Gaps inside the pattern.
        load(4'b1011, 1'b1, 1'b0, 1'b0);
        sample(1'b1, 1'b0, 1'b0, "gap_s1");
        idle("gap_i1");
        sample(1'b0, 1'b0, 1'b0, "gap_s2");
        idle("gap_i2");
        idle("gap_i3");
        sample(1'b1, 1'b0, 1'b0, "gap_s3");
        idle("gap_i4");
        sample(1'b1, 1'b0, 1'b1, "gap_s4");
        idle("gap_i5");

        // Saturation at 3 with five matches, then clear with a match.
        clr_cycle("clr3");
        load(4'b1011, 1'b1, 1'b0, 1'b0);
        run(16'b1011011011011, 16'b0001001001001, 13, "sat");
        run(16'b011, 16'b001, 3, "sat5");
        chk("sat_count", int'(bus.match_count), ec(3));
        sample(1'b0, 1'b0, 1'b0, "cm_1");
        sample(1'b1, 1'b0, 1'b0, "cm_2");
        sample(1'b1, 1'b1, 1'b1, "cm_3");
        chk("cm_count", int'(bus.match_count), ec(1));

        // Reset three bits into a pattern.
        load(4'b1011, 1'b1, 1'b0, 1'b0);
        run(16'b101, 16'b000, 3, "mid");
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_match", int'(bus.match), 0);
        chk("mid_armed", int'(bus.armed), 0);
        chk("mid_count", int'(bus.match_count), 0);
        chk("mid_state", int'(dut.state_q), int'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        sample(1'b1, 1'b0, 1'b0, "post_1");
        run(16'b1011, 16'b0000, 4, "post");
        chk("post_armed", int'(bus.armed), 0);
        chk("post_count", int'(bus.match_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
